id_ex_operand_stage: RTL

ID/EX pipeline stage of the pipelined MIPS core. It sits directly upstream of the EX-stage ALU and drives that ALU's src1, src2 and 4-bit ctrl inputs.
- Registers decoded ID-stage fields and decodes ALUOp/funct into the ALU control code.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles.

---
 rtl/id_ex_operand_stage.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// ID/EX pipeline register of the pipelined MIPS core, feeding the EX-stage ALU.
// - Captures the decoded ID fields and turns ALUOp/funct into the 4-bit ALU code.
// - Forwards EX/MEM and MEM/WB results onto the registered rs/rt operands.
// - Requests a one-cycle hold of PC and IF/ID on a load-use hazard and
//   inserts a bubble into EX on the same edge.
//
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add bubble_cnt_o, a
// saturating count of edges that inserted a bubble (flush or load-use).
//
// Ports:
//   clk_i, rst_i             clock (rising edge), synchronous active-high reset
//   stall_i, flush_i         external hold / kill of the stage contents
//   id_*                     ID-stage instruction fields and control bits
//   exmem_*, memwb_*         forwarding sources (write enable, dest, value)
//   src1_o, src2_o           ALU operands (forwarded rs, immediate or forwarded rt)
//   alu_ctrl_o               ALU control code
//   store_data_o             forwarded rt for stores
//   ex_valid_o, ex_dst_o     EX slot valid flag and resolved destination
//   ex_reg_write_o           registered write enable (0 when the slot is empty)
//   ex_mem_read_o            registered load flag (0 when the slot is empty)
//   illegal_o                unsupported R-type funct
//   bubble_cnt_o             bubble counter (only with ID_EX_BUBBLE_CNT_EN)
//   load_use_stall_o         combinational hold request to PC and IF/ID
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_addr_i,
  input  logic [REG_AW-1:0] id_rt_addr_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic [1:0]        id_alu_op_i,
  input  logic [5:0]        id_funct_i,
  input  logic              id_alu_src_i,
  input  logic              id_reg_dst_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [3:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic              ex_valid_o,
  output logic [REG_AW-1:0] ex_dst_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              illegal_o,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [31:0]       bubble_cnt_o,
`endif
  output logic              load_use_stall_o
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Registered EX-slot state
  logic              valid_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] rs_addr_q;
  logic [REG_AW-1:0] rt_addr_q;
  logic [REG_AW-1:0] dst_q;
  logic [3:0]        alu_ctrl_q;
  logic              alu_src_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic              illegal_q;

  logic [3:0]        alu_ctrl_d;
  logic              illegal_d;
  logic              load_use;
  logic              bubble;

  // ALU control decode of the incoming ID instruction
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    alu_ctrl_d = ALU_ADD;
    illegal_d  = 1'b0;
    case (id_alu_op_i)
      2'b00: alu_ctrl_d = ALU_ADD;
      2'b01: alu_ctrl_d = ALU_SUB;
      2'b11: alu_ctrl_d = ALU_SLT;
      default: begin
        case (id_funct_i)
          6'b100000: alu_ctrl_d = ALU_ADD;
          6'b100010: alu_ctrl_d = ALU_SUB;
          6'b100100: alu_ctrl_d = ALU_AND;
          6'b100101: alu_ctrl_d = ALU_OR;
          6'b101010: alu_ctrl_d = ALU_SLT;
          default:   illegal_d  = 1'b1;
        endcase
      end
    endcase
  end

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // Reset and flush kill the EX slot anyway, so no hold is requested then.
  assign load_use = !rst_i && !flush_i && valid_q && mem_read_q &&
                    (dst_q != '0) && id_valid_i &&
                    ((dst_q == id_rs_addr_i) || (dst_q == id_rt_addr_i));

  // Reset, flush, a load-use bubble and an empty ID slot all leave EX in the
  // same empty state. flush beats stall; a load-use bubble waits out a stall.
  assign bubble = rst_i || flush_i || (!stall_i && (load_use || !id_valid_i));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (bubble) begin
      valid_q     <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      dst_q       <= '0;
      alu_ctrl_q  <= ALU_ADD;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (!stall_i) begin
      valid_q     <= 1'b1;
      rs_data_q   <= id_rs_data_i;
      rt_data_q   <= id_rt_data_i;
      imm_q       <= id_imm_i;
      rs_addr_q   <= id_rs_addr_i;
      rt_addr_q   <= id_rt_addr_i;
      dst_q       <= id_reg_dst_i ? id_rd_addr_i : id_rt_addr_i;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_src_q   <= id_alu_src_i;
      reg_write_q <= id_reg_write_i;
      mem_read_q  <= id_mem_read_i;
      illegal_q   <= illegal_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;
  logic        bubble_cnt_inc;

  // Only flush and load-use bubbles count; a plain stall or empty slot does not.
  assign bubble_cnt_inc = !rst_i && (flush_i || (!stall_i && load_use));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
    end else if (bubble_cnt_inc && (bubble_cnt_q != '1)) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

  // Forwarding: EX/MEM wins over MEM/WB; register 0 is never forwarded.
  function automatic logic [DATA_W-1:0] forward(input logic [REG_AW-1:0] addr,
                                                input logic [DATA_W-1:0] reg_data);
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == addr)) begin
      return exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == addr)) begin
      return memwb_result_i;
    end
    return reg_data;
  endfunction

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  assign rs_fwd = forward(rs_addr_q, rs_data_q);
  assign rt_fwd = forward(rt_addr_q, rt_data_q);

  assign src1_o           = rs_fwd;
  assign src2_o           = alu_src_q ? imm_q : rt_fwd;
  assign store_data_o     = rt_fwd;
  assign alu_ctrl_o       = alu_ctrl_q;
  assign ex_valid_o       = valid_q;
  assign ex_dst_o         = dst_q;
  assign ex_reg_write_o   = reg_write_q;
  assign ex_mem_read_o    = mem_read_q;
  assign illegal_o        = illegal_q;
  assign load_use_stall_o = load_use;

endmodule
